dir_queue: RTL and testbench

- Sits between the four button debouncers and the snek game core, in the 25 MHz VGA clock domain.
- Synchronises the debounced press pulses, which come from the 16 MHz domain, and edge-detects them.
- Filters out illegal moves: reversals and repeats of the current direction.
- Buffers legal moves in a small FIFO and releases one per game-step tick as the snake heading.
- Lets fast players queue turns between steps without losing them.

---
 rtl/snek_pkg.sv | 21 ++
 rtl/btn_sync.sv | 36 +++
 rtl/dir_queue.sv | 134 +++++++++++++
 tb/tb_dir_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snek_pkg.sv
// Shared direction/button encodings for the snek game input path.
package snek_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 0;

    // Same axis (bit 1) but opposite sense (bit 0) means a 180-degree turn.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser per bit followed by a rising-edge detector.
module btn_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d[0] = din_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // A pulse sampled on several consecutive edges still yields one event.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/dir_queue.sv
// Button-press direction filter and FIFO feeding the snek heading, one move per tick.
// Optional DIR_QUEUE_FLUSH_EN adds a flush input that clears the queue and heading.
module dir_queue
    import snek_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef DIR_QUEUE_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic [3:0]             btn_dn,
    input  logic                   tick,
    output logic [1:0]             dir,
    output logic                   dir_chg,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [3:0]            rise;
    dir_t                  cand, tail;
    logic                  cand_vld, legal, full, empty, enq, deq, ovf_set;
    logic [PtrW-1:0]       last_idx;

    dir_t [DEPTH-1:0]      mem_q, mem_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    dir_t                  dir_q, dir_d;
    logic                  chg_q, chg_d;
    logic                  ovf_q, ovf_d;

    btn_sync #(
        .WIDTH       (4),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .din_i  (btn_dn),
        .rise_o (rise)
    );

    always_comb begin
        cand     = DIR_RIGHT;
        cand_vld = 1'b1;
        if (rise[BTN_UP]) begin
            cand = DIR_UP;
        end else if (rise[BTN_DOWN]) begin
            cand = DIR_DOWN;
        end else if (rise[BTN_LEFT]) begin
            cand = DIR_LEFT;
        end else if (rise[BTN_RIGHT]) begin
            cand = DIR_RIGHT;
        end else begin
            cand_vld = 1'b0;
        end
    end

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign last_idx = wr_ptr_q - PtrW'(1);
    // Moves are judged against where the snake will be heading once the queue drains.
    assign tail     = empty ? dir_q : mem_q[last_idx];
    assign legal    = cand_vld && (cand != tail) && !is_reverse(cand, tail);
    assign deq      = tick && !empty;
    assign enq      = legal && (!full || deq);
    assign ovf_set  = legal && full && !deq;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dir_d    = dir_q;
        chg_d    = 1'b0;
        ovf_d    = ovf_q || ovf_set;

        if (deq) begin
            dir_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            chg_d    = 1'b1;
        end
        if (enq) begin
            mem_d[wr_ptr_q] = cand;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CntW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CntW'(1);
        end

`ifdef DIR_QUEUE_FLUSH_EN
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            dir_d    = DIR_RIGHT;
            chg_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dir_q    <= DIR_RIGHT;
            chg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            chg_q    <= chg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dir      = dir_q;
    assign dir_chg  = chg_q;
    assign q_count  = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_dir_queue.sv
// Bench for dir_queue: directed per-cycle vector table, then random presses/ticks vs a queue model.
module tb_dir_queue;
    import snek_pkg::*;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CntW        = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      btn_dn = 4'b0000;
    logic            tick = 1'b0;
    logic            flush_drv = 1'b0;
`ifdef DIR_QUEUE_FLUSH_EN
    logic            flush;
    assign flush = flush_drv;
`endif
    logic [1:0]      dir;
    logic            dir_chg;
    logic [CntW-1:0] q_count;
    logic            overflow;

    int n_tests = 0;
    int n_fail  = 0;

    dir_queue #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DIR_QUEUE_FLUSH_EN
        .flush    (flush),
`endif
        .btn_dn   (btn_dn),
        .tick     (tick),
        .dir      (dir),
        .dir_chg  (dir_chg),
        .q_count  (q_count),
        .overflow (overflow)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [3:0]      btn;
        logic            tick;
        logic [1:0]      dir;
        logic            chg;
        logic [CntW-1:0] cnt;
        logic            ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] b, input logic t, input logic [1:0] d,
                                input logic c, input int n, input logic o);
        vec_t v;
        v.btn = b; v.tick = t; v.dir = d; v.chg = c; v.cnt = CntW'(n); v.ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] ed, input logic ec,
                         input logic [CntW-1:0] en, input logic eo);
        n_tests++;
        if (dir !== ed || dir_chg !== ec || q_count !== en || overflow !== eo) begin
            n_fail++;
            $display("FAIL %s: got dir=%0d chg=%0b cnt=%0d ovf=%0b, want dir=%0d chg=%0b cnt=%0d ovf=%0b",
                     name, dir, dir_chg, q_count, overflow, ed, ec, en, eo);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic [3:0] b, input logic t, input logic f);
        @(negedge clk);
        btn_dn    = b;
        tick      = t;
        flush_drv = f;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: heading plus a queue of pending turns.
    dir_t       m_q[$];
    dir_t       m_dir;
    logic       m_chg, m_ovf;
    logic [3:0] m_prev;
    logic [3:0] m_pipe[$];

    function automatic void model_reset();
        m_q.delete();
        m_dir  = DIR_RIGHT;
        m_chg  = 1'b0;
        m_ovf  = 1'b0;
        m_prev = 4'b0000;
        m_pipe.delete();
        for (int i = 0; i < int'(SYNC_STAGES); i++) m_pipe.push_back(4'b0000);
    endfunction

    function automatic void model_step(input logic [3:0] b, input logic t, input logic f);
        logic [3:0] ev;
        dir_t       tl, cd;
        bit         have, ok, pop;
        m_pipe.push_back(b & ~m_prev);
        m_prev = b;
        ev = m_pipe.pop_front();
        if (f) begin
            m_q.delete();
            m_dir = DIR_RIGHT;
            m_chg = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        tl   = (m_q.size() > 0) ? m_q[$] : m_dir;
        have = 1'b1;
        cd   = DIR_RIGHT;
        if (ev[3])      cd = DIR_UP;
        else if (ev[2]) cd = DIR_DOWN;
        else if (ev[1]) cd = DIR_LEFT;
        else if (ev[0]) cd = DIR_RIGHT;
        else            have = 1'b0;
        // Up/down form the vertical axis; a different move on the same axis is a reversal.
        ok  = have && (cd != tl) && ((cd < 2'd2) != (tl < 2'd2));
        pop = t && (m_q.size() > 0);
        m_chg = pop;
        if (pop) m_dir = m_q.pop_front();
        if (ok) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(cd);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic apply_reset(input string name);
        @(negedge clk);
        #5;
        rst       = 1'b0;
        btn_dn    = 4'b0000;
        tick      = 1'b0;
        flush_drv = 1'b0;
        #1;
        check(name, 2'b11, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] b;
        logic       t, f;

        // Directed per-cycle vectors; press events land SYNC_STAGES edges after first sampled.
        add(4'h0,0,3,0,0,0); add(4'h0,1,3,0,0,0); add(4'h0,1,3,0,0,0); add(4'h0,1,3,0,0,0);
        add(4'h2,0,3,0,0,0); add(4'h0,0,3,0,0,0); add(4'h0,0,3,0,0,0);   // left vs right: reversal
        add(4'h1,0,3,0,0,0); add(4'h0,0,3,0,0,0); add(4'h0,0,3,0,0,0);   // right: duplicate
        add(4'h8,0,3,0,0,0); add(4'h8,0,3,0,0,0); add(4'h0,0,3,0,1,0);   // 2-cycle up pulse
        add(4'h0,1,0,1,0,0); add(4'h0,0,0,0,0,0);
        add(4'h4,0,0,0,0,0); add(4'h0,0,0,0,0,0); add(4'h0,0,0,0,0,0);   // down vs up: reversal
        add(4'h8,0,0,0,0,0); add(4'h0,0,0,0,0,0); add(4'h0,0,0,0,0,0);   // up: duplicate
        add(4'h2,0,0,0,0,0); add(4'h4,0,0,0,0,0); add(4'h1,0,0,0,1,0);   // fill: L D R U
        add(4'h8,0,0,0,2,0); add(4'h0,0,0,0,3,0); add(4'h0,0,0,0,4,0);
        add(4'h2,0,0,0,4,0); add(4'h0,0,0,0,4,0); add(4'h0,1,2,1,4,0);   // full + tick + press
        add(4'h4,0,2,0,4,0); add(4'h0,0,2,0,4,0); add(4'h0,0,2,0,4,1);   // full: overflow
        add(4'h0,1,1,1,3,1); add(4'h0,1,3,1,2,1); add(4'h0,1,0,1,1,1); add(4'h0,1,2,1,0,1);
        add(4'h0,1,2,0,0,1);                                             // tick on empty
        add(4'hA,0,2,0,0,1); add(4'h0,0,2,0,0,1); add(4'h0,0,2,0,1,1);   // up+left: up wins
        add(4'h0,1,0,1,0,1);
        add(4'h5,0,0,0,0,1); add(4'h0,0,0,0,0,1); add(4'h0,0,0,0,0,1);   // down+right: down, dropped
        add(4'h3,0,0,0,0,1); add(4'h0,0,0,0,0,1); add(4'h0,0,0,0,1,1);   // left+right: left
        add(4'h0,1,2,1,0,1); add(4'h0,0,2,0,0,1);
        add(4'h8,0,2,0,0,1); add(4'h0,0,2,0,0,1); add(4'h0,1,2,0,1,1);   // empty + tick + press
        add(4'h0,1,0,1,0,1);

        apply_reset("reset_start");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn, vecs[i].tick, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].dir, vecs[i].chg, vecs[i].cnt, vecs[i].ovf);
        end

`ifdef DIR_QUEUE_FLUSH_EN
        step(4'h2, 1'b0, 1'b0); step(4'h4, 1'b0, 1'b0); step(4'h1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0); step(4'h0, 1'b0, 1'b0);
        check("flush_pre", 2'b00, 1'b0, CntW'(3), 1'b1);
        step(4'h0, 1'b0, 1'b1);
        check("flush", 2'b11, 1'b0, '0, 1'b0);
`endif

        apply_reset("reset_random");
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) apply_reset("reset_midrun");
            for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 4) == 0);
            t = ($urandom_range(0, 5) == 0);
            f = 1'b0;
`ifdef DIR_QUEUE_FLUSH_EN
            f = ($urandom_range(0, 99) == 0);
`endif
            step(b, t, f);
            model_step(b, t, f);
            check($sformatf("rand%0d", c), m_dir, m_chg, CntW'(m_q.size()), m_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
